serial_bit_source: RTL

Parallel-to-serial stimulus stage that feeds the single-bit `X` input of the lab sequence-detector FSMs (Mealy/Moore). It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per `clk` on `x`, with a `x_valid` qualifier. An optional idle gap can be inserted between words. The detector then consumes `x` directly, with no glue logic.

---
 rtl/serial_src_pkg.sv | 20 ++
 rtl/down_counter.sv | 32 +++
 rtl/serial_bit_source.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_src_pkg.sv
// Shared definitions for the serial bit source.
//   state_t : FSM state encoding (IDLE=0, SHIFT=1, GAP=2)
//   GAP_W   : width of the idle-gap counter (gap length 0..255)
//   cnt_w() : width of the bit counter needed for a given word width
package serial_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int GAP_W = 8;

  // The bit counter only has to hold WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with zero flag.
//   clk, rst : clock and asynchronous active-high reset (count -> 0)
//   load     : load value (has priority over dec)
//   dec      : decrement by one; holds at zero
//   value    : value to load
//   zero     : count is zero
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stimulus stage for a single-bit sequence detector input.
// Accepts a WIDTH-bit word over load_valid/load_ready and emits it one bit
// per clock on x, qualified by x_valid, with an optional idle gap afterwards.
//
// Handshake: a word transfers on any posedge where load_valid && load_ready.
// load_ready depends on registered state only; load_data is ignored while
// load_ready is low, so the word in flight is never disturbed.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_valid : word on load_data is offered
//   load_data  : word to serialize
//   load_ready : block can accept a word this cycle
//   x          : serial data bit (0 when x_valid is low)
//   x_valid    : x carries a data bit this cycle
//   word_done  : high while the last bit of a word is on x
//   busy       : state is SHIFT or GAP
//   dbg_state  : current FSM state (serial_src_pkg::state_t encoding)
module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_INIT = HAS_GAP ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam bit               LSB_OUT  = (LSB_FIRST != 0);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic             out_bit;
  logic             in_shift;
  logic             last_bit;
  logic             accept;
  logic             bit_zero;
  logic             gap_zero;
  logic             bit_load;
  logic             bit_dec;
  logic             gap_load;
  logic             gap_dec;

  // The output end of the register is bit WIDTH-1 for MSB-first and bit 0
  // for LSB-first; shifting always moves the next bit toward that end.
  always_comb begin
    out_bit      = LSB_OUT ? sreg[0] : sreg[WIDTH-1];
    sreg_shifted = LSB_OUT ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    in_shift   = (state == S_SHIFT);
    last_bit   = in_shift && bit_zero;
    // In gapless mode the next word is taken while the last bit is on x.
    load_ready = (state == S_IDLE) || (last_bit && !HAS_GAP);
    accept     = load_valid && load_ready;
    bit_load   = accept;
    bit_dec    = in_shift && !bit_zero;
    gap_load   = last_bit && HAS_GAP;
    gap_dec    = (state == S_GAP) && !gap_zero;
  end

  // Outputs decode registered state only.
  assign x         = in_shift && out_bit;
  assign x_valid   = in_shift;
  assign word_done = last_bit;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  down_counter #(.W(CNT_W)) bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (bit_load),
    .dec   (bit_dec),
    .value (LAST_IDX),
    .zero  (bit_zero)
  );

  down_counter #(.W(GAP_W)) gap_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (gap_load),
    .dec   (gap_dec),
    .value (GAP_INIT),
    .zero  (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg  <= load_data;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!bit_zero) begin
            sreg <= sreg_shifted;
          end else if (HAS_GAP) begin
            state <= S_GAP;
          end else if (accept) begin
            sreg <= load_data;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
